// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants for the inverse key schedule.
//   NUM_ROUNDS / KEY_BITS : AES-256 round count and key width.
//   SBOX                  : forward AES S-box, indexed by the input byte.
//   RCON                  : round constant high bytes; RCON[k] is used when
//                           recovering word 8k-8 (entry 0 is unused).
//   state_e               : state encoding of the inverse schedule FSM.
package aes_pkg;

    localparam int NUM_ROUNDS = 14;
    localparam int KEY_BITS   = 256;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/sub_word.sv
// sub_word: AES SubWord, four parallel S-box lookups on a 32-bit word.
//   word_i : input word
//   word_o : S-box substituted word (byte-wise)
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign word_o[gi*8 +: 8] = SBOX[word_i[gi*8 +: 8]];
    end

endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: walks the AES-256 key expansion backwards. Given the
// last eight expanded words (w52..w59) it emits round keys 14 down to 0,
// one per accepted output handshake, and exposes the recovered cipher key.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, ready_o     : input handshake for final_key_i (w52 in the top bits)
//   v_o, ready_i     : output handshake for round_key_o
//   round_key_o      : current round key, first word in the top bits
//   round_idx_o      : round index of round_key_o (14..0)
//   last_o           : marks round key 0
//   cipher_key_o     : recovered w0..w7, valid while last_o is high
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                v_i,
    output logic                ready_o,
    input  logic [KEY_BITS-1:0] final_key_i,
    output logic                v_o,
    input  logic                ready_i,
    output logic [127:0]        round_key_o,
    output logic [3:0]          round_idx_o,
    output logic                last_o,
    output logic [KEY_BITS-1:0] cipher_key_o
);

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [KEY_BITS-1:0] window_q, window_d;

    // Window words w[j..j+7], w[j] in the top 32 bits.
    logic [31:0] w_j3, w_j4, w_j5, w_j6, w_j7;
    logic [31:0] w_m1, w_m2, w_m3, w_m4;
    logic [31:0] f_in, f_sub, f_out;
    logic        rot_step;

    assign w_j3 = window_q[159:128];
    assign w_j4 = window_q[127:96];
    assign w_j5 = window_q[95:64];
    assign w_j6 = window_q[63:32];
    assign w_j7 = window_q[31:0];

    // With idx = r the word being undone is w[4r]; it sits on a multiple of
    // eight (RotWord + Rcon[r/2]) exactly when r is even.
    assign rot_step = ~idx_q[0];
    assign f_in     = rot_step ? {w_j3[23:0], w_j3[31:24]} : w_j3;

    sub_word u_sub_word (
        .word_i (f_in),
        .word_o (f_sub)
    );

    assign f_out = rot_step ? (f_sub ^ {RCON[idx_q[3:1]], 24'h0}) : f_sub;

    assign w_m1 = w_j7 ^ w_j6;
    assign w_m2 = w_j6 ^ w_j5;
    assign w_m3 = w_j5 ^ w_j4;
    assign w_m4 = w_j4 ^ f_out;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        window_d = window_q;
        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    state_d  = ST_EMIT;
                    idx_d    = 4'(NUM_ROUNDS);
                    window_d = final_key_i;
                end
            end
            ST_EMIT: begin
                if (ready_i) begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q - 4'd1;
                        // At idx 1 the window already holds w0..w7, which
                        // also serves round key 0.
                        if (idx_q > 4'd1) begin
                            window_d = {w_m4, w_m3, w_m2, w_m1, window_q[255:128]};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            window_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            window_q <= window_d;
        end
    end

    // Every output is a decode of flops only; ready_i never reaches them
    // combinationally.
    assign ready_o      = (state_q == ST_IDLE);
    assign v_o          = (state_q == ST_EMIT);
    assign round_idx_o  = idx_q;
    assign last_o       = (state_q == ST_EMIT) && (idx_q == 4'd0);
    assign round_key_o  = (idx_q == 4'd0) ? window_q[255:128] : window_q[127:0];
    assign cipher_key_o = window_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: scoreboard bench for inv_key_schedule. An independent
// forward AES-256 key expansion (S-box derived from GF(2^8) inversion) fills
// the expected queue at each accepted job; a negedge monitor pops and
// compares on every output handshake.
module tb_inv_key_schedule;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         v_i = 1'b0;
    logic [255:0] final_key_i = '0;
    logic [1:0]   ready_mode = 2'd1;   // 0: low, 1: high, 2: random
    logic         rnd_bit = 1'b0;
    logic         ready_i;
    logic         ready_o, v_o, last_o;
    logic [127:0] round_key_o;
    logic [3:0]   round_idx_o;
    logic [255:0] cipher_key_o;

    assign ready_i = (ready_mode == 2'd1) || ((ready_mode == 2'd2) && rnd_bit);

    inv_key_schedule dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .final_key_i  (final_key_i),
        .v_o          (v_o),
        .ready_i      (ready_i),
        .round_key_o  (round_key_o),
        .round_idx_o  (round_idx_o),
        .last_o       (last_o),
        .cipher_key_o (cipher_key_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_m [256];
    logic [31:0] w_m [60];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [7:0]  rc;
        logic [31:0] temp;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w_m[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w_m[i-1];
            if (i % 8 == 0) begin
                temp = subword_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                temp = subword_m(temp);
            end
            w_m[i] = w_m[i-8] ^ temp;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         last;
        logic [255:0] ck;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic push_job(input logic [255:0] key);
        exp_t e;
        expand_key(key);
        for (int r = 14; r >= 0; r--) begin
            e.idx  = 4'(r);
            e.rk   = {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
            e.last = (r == 0);
            e.ck   = key;
            sb_q.push_back(e);
        end
    endtask

    logic [127:0] obs_rk [16];
    logic [255:0] obs_ck = '0;
    int           last0_cyc = -100;
    int           acc_cyc = 0;
    logic         stall_prev = 1'b0;
    logic [132:0] stall_snap = '0;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check_val("hold_stable", {v_o, round_idx_o, round_key_o}, stall_snap);
            if (v_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_output", {252'b0, round_idx_o}, 256'h10);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("idx", round_idx_o, mon_e.idx);
                    check_val("round_key", round_key_o, mon_e.rk);
                    check_val("last", last_o, mon_e.last);
                    if (mon_e.last) begin
                        check_val("cipher_key", cipher_key_o, mon_e.ck);
                        obs_ck = cipher_key_o;
                        last0_cyc = cyc;
                    end
                    obs_rk[round_idx_o] = round_key_o;
                end
            end
            stall_prev = v_o && !ready_i;
            stall_snap = {v_o, round_idx_o, round_key_o};
        end
    end

    // ---------------- driver helpers ----------------
    task automatic start_job(input logic [255:0] key, input bit keep_v);
        bit ok;
        ok = 1'b0;
        expand_key(key);
        final_key_i = {w_m[52], w_m[53], w_m[54], w_m[55], w_m[56], w_m[57], w_m[58], w_m[59]};
        v_i = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                push_job(key);
                acc_cyc = cyc;
                ok = 1'b1;
            end
        end
        if (!ok) check_val("accept_timeout", {255'b0, ready_o}, 256'h1);
        @(posedge clk_i); #1;
        if (!keep_v) v_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk_i);
            if (sb_q.size() == 0) break;
        end
        #1;
        if (sb_q.size() != 0) check_val({tag, "_timeout"}, sb_q.size(), 0);
        check_val({tag, "_idle"}, {v_o, ready_o}, 2'b01);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk_i);
            if (v_o && round_idx_o == target) ok = 1'b1;
        end
        if (!ok) check_val("wait_idx_timeout", {v_o, round_idx_o}, {1'b1, target});
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] k_a;
        build_sbox();

        // Reset values
        reset_n_i = 1'b0;
        @(posedge clk_i); #1;
        check_val("rst_ready", ready_o, 1'b1);
        check_val("rst_v", v_o, 1'b0);
        check_val("rst_last", last_o, 1'b0);
        check_val("rst_idx", round_idx_o, 4'd0);
        check_val("rst_round_key", round_key_o, 128'h0);
        check_val("rst_cipher_key", cipher_key_o, 256'h0);
        @(negedge clk_i) reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // FIPS-197 C.3 key, ready held high
        ready_mode = 2'd1;
        start_job(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        wait_done("fips");
        check_val("fips_rk14", obs_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check_val("fips_rk13", obs_rk[13], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
        check_val("fips_rk0", obs_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
        check_val("fips_cipher_key", obs_ck,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // Stall 20 cycles at idx 7
        start_job(rand_key(), 1'b0);
        wait_idx(4'd8);
        @(posedge clk_i); #1;
        ready_mode = 2'd0;
        check_val("stall_entry_idx", round_idx_o, 4'd7);
        repeat (20) @(posedge clk_i);
        #1;
        check_val("stall_exit_idx", {v_o, round_idx_o}, {1'b1, 4'd7});
        ready_mode = 2'd1;
        wait_done("stall");

        // v_i pulsed with a different key during EMIT
        start_job(rand_key(), 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        final_key_i = rand_key();
        v_i = 1'b1;
        check_val("busy_ready", ready_o, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        v_i = 1'b0;
        wait_done("ignore_vi");

        // Reset at idx 5, then a fresh job
        start_job(rand_key(), 1'b0);
        wait_idx(4'd5);
        #1;
        reset_n_i = 1'b0;
        #1;
        check_val("midrst_v", v_o, 1'b0);
        check_val("midrst_ready", ready_o, 1'b1);
        check_val("midrst_idx", round_idx_o, 4'd0);
        sb_q.delete();
        @(negedge clk_i) reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        start_job(rand_key(), 1'b0);
        wait_done("post_reset");

        // Back-to-back with v_i held high
        k_a = rand_key();
        start_job(k_a, 1'b1);
        start_job(rand_key(), 1'b0);
        check_val("b2b_gap", acc_cyc - last0_cyc, 1);
        wait_done("b2b");

        // Random keys with random ready
        ready_mode = 2'd2;
        for (int j = 0; j < 1000; j++) begin
            start_job(rand_key(), 1'b0);
            wait_done("rand");
        end
        ready_mode = 2'd1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 reset_n_i  input  1  asynchronous active-low reset.
REQ-004 v_i  input  1  final_key_i valid.
REQ-005 ready_o  output  1  block can accept final_key_i.
REQ-006 final_key_i  input  256  AES-256 expanded-key words w52..w59 (round keys 13 and 14), bit 0 = MSB of w52.
REQ-007 v_o  output  1  round_key_o valid.
REQ-008 ready_i  input  1  consumer accepts round_key_o.
REQ-009 round_key_o  output  128  current round key, MSB-first word order.
REQ-010 round_idx_o  output  4  round index of round_key_o, 14 down to 0.
REQ-011 last_o  output  1  high with v_o when round_idx_o == 0.
REQ-012 cipher_key_o  output  256  recovered original key w0..w7; meaningful only while last_o is high.

Function
REQ-013 The FSM SHALL have two states, IDLE and EMIT; ready_o = 1 only in IDLE, and v_o = 1 only in EMIT.
REQ-014 IDLE -> EMIT on v_i && ready_o: load the 256-bit window with final_key_i and set idx = 14; v_o rises the next cycle (1-cycle latency).
REQ-015 The window SHALL hold w[4r-4 .. 4r+3] while idx = r >= 1; round_key_o = window[128:255] for idx >= 1, and window[0:127] for idx == 0.
REQ-016 Handshake v_o && ready_i with idx > 1 SHALL shift the window to {new4, window[0:127]} and decrement idx.
REQ-017 Handshake at idx == 1 SHALL only decrement idx, with no shift.
REQ-018 Handshake at idx == 0 SHALL return to IDLE; ready_o = 1 on the following cycle, so there is one bubble between jobs.
REQ-019 Backward step, with window = w[j..j+7]:
- w[j-1] = w[j+7] ^ w[j+6]
- w[j-2] = w[j+6] ^ w[j+5]
- w[j-3] = w[j+5] ^ w[j+4]
- w[j-4] = w[j+4] ^ f(w[j+3])
REQ-020 f(x) SHALL be SubWord(RotWord(x)) ^ {Rcon[(j+4)/8], 24'h0} when (j+4) mod 8 == 0, and SubWord(x) when (j+4) mod 8 == 4.
REQ-021 Rcon index SHALL be 7, 6, ..., 1; exactly one SubWord (4 S-box lookups) is needed per step.
REQ-022 With ready_i low, round_key_o, round_idx_o, v_o and the window SHALL be held stable.
REQ-023 v_i asserted while in EMIT SHALL be ignored (ready_o = 0), and no state is corrupted.
REQ-024 cipher_key_o SHALL equal the window whenever idx <= 1.
REQ-025 Exactly 15 round keys SHALL be emitted per accepted final_key_i.

Reset
REQ-026 When reset_n_i = 0, the block SHALL immediately enter IDLE and drive ready_o = 1, v_o = 0, last_o = 0, round_idx_o = 0, window = 0, round_key_o = 0 and cipher_key_o = 0.
REQ-027 Reset mid-job SHALL discard the job; the first post-reset handshake SHALL start a fresh sequence at idx 14.

Structure
REQ-028 The shared package aes_pkg SHALL hold the S-box table, the Rcon table, and constants NUM_ROUNDS = 14 and KEY_BITS = 256.
REQ-029 One sub-module, sub_word, SHALL perform the 32-bit SubWord via four S-box lookups; RotWord and the XOR logic stay in inv_key_schedule.
REQ-030 round_key_o SHALL be driven from registered state, with no combinational path from ready_i to round_key_o.

Verification
REQ-031 FIPS-197 C.3 key 000102..1f: final_key_i = w52..w59 with ready_i held 1 -> first output idx 14 = 24fc79ccbf0979e9371ac23c6d68de36, then idx 13 = 4e5a6699a9f24fe07e572baacdf8cdea, ... idx 0 = 000102030405060708090a0b0c0d0e0f with last_o = 1, and cipher_key_o = 000102..1f.
REQ-032 Random ready_i (50%), 1000 random keys: the emitted sequence SHALL equal the reverse of the reference forward expansion, with no duplicated or dropped idx values.
REQ-033 ready_i held low for 20 cycles at idx 7 -> outputs stable; after release, idx 6 appears next.
REQ-034 v_i pulsed during EMIT with a different key -> ignored; the original 15-key sequence completes.
REQ-035 reset_n_i asserted at idx 5 -> v_o = 0 immediately; a new job then emits from idx 14 correctly.
REQ-036 Back-to-back jobs with v_i held high -> second acceptance occurs exactly 1 cycle after the idx 0 handshake.
